// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets one requester at a time stream a whole
// packet into a shared downstream FIFO. Ownership is taken in IDLE, held in
// LOCKED until the owner's last word (or a packet longer than MAX_BEATS),
// then the round-robin pointer moves past the finished owner.
//
// Handshake: a word moves from requester r on a rising edge where
// i_valid[r] and o_ready[r] are both high. o_ready never depends on
// i_valid. Only the owner can see ready, and only while the FIFO is not full
// and reset is low. The accepted word appears on o_fifo_data with
// o_fifo_write_en in that same cycle.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16,
  localparam int GID_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_valid,
  input  logic [NUM_REQ-1:0]            i_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_ready,
  output logic                          o_fifo_write_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_data,
  input  logic                          i_fifo_full,
  output logic [GID_W-1:0]              o_grant_id,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic                          o_dbg_state,
  output logic [GID_W-1:0]              o_dbg_rr_ptr
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [GID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              overflow_q, overflow_d;

  logic              found;
  logic [GID_W-1:0]  pick;
  logic [GID_W-1:0]  next_ptr;
  logic              locked;
  logic              xfer;
  logic              owner_last;
  logic              force_release;

  // Pick the first valid requester at or after rr_ptr, wrapping upward.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && i_valid[idx]) begin
        found = 1'b1;
        pick  = GID_W'(idx);
      end
    end
  end

  // Owner datapath: ready/write strobe gating and zero-latency data passthrough.
  always_comb begin
    locked          = (state_q == S_LOCKED);
    owner_last      = i_last[grant_q];
    o_ready         = '0;
    if (locked && !i_fifo_full && !i_rst) o_ready[grant_q] = 1'b1;
    xfer            = locked && !i_fifo_full && !i_rst && i_valid[grant_q];
    o_fifo_write_en = xfer;
    o_fifo_data     = i_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    force_release   = xfer && !owner_last && (beat_q == CNT_W'(MAX_BEATS - 1));
    next_ptr        = (grant_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  end

  // Next-state: grant in IDLE, count beats and release on last/overflow in LOCKED.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_d     = beat_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_LOCKED;
          grant_d = pick;
          beat_d  = '0;
        end
      end
      S_LOCKED: begin
        if (xfer) begin
          beat_d = beat_q + 1'b1;
          if (owner_last || force_release) begin
            state_d  = S_IDLE;
            rr_ptr_d = next_ptr;
          end
          if (force_release) overflow_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; synchronous reset wins over any packet in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_grant_id   = grant_q;
  assign o_busy       = (state_q == S_LOCKED);
  assign o_overflow   = overflow_q;
  assign o_dbg_state  = state_q;
  assign o_dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester packet drivers, a write
// monitor that pops the expected word queue, and cycle-level spot checks.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   i_valid;
  logic [NR-1:0]   i_last;
  logic [NR*DW-1:0] i_data;
  logic [NR-1:0]   o_ready;
  logic            o_fifo_write_en;
  logic [DW-1:0]   o_fifo_data;
  logic            fifo_full;
  logic [1:0]      o_grant_id;
  logic            o_busy;
  logic            o_overflow;
  logic            o_dbg_state;
  logic [1:0]      o_dbg_rr_ptr;

  logic            v_r [NR];
  logic            l_r [NR];
  logic [DW-1:0]   d_r [NR];

  logic [DW-1:0]   exp_q[$];
  int              wr_cyc[$];
  logic [DW-1:0]   mon_exp;
  int              checks;
  int              errors;
  int              cyc;
  int              scen;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(16)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_valid         (i_valid),
    .i_last          (i_last),
    .i_data          (i_data),
    .o_ready         (o_ready),
    .o_fifo_write_en (o_fifo_write_en),
    .o_fifo_data     (o_fifo_data),
    .i_fifo_full     (fifo_full),
    .o_grant_id      (o_grant_id),
    .o_busy          (o_busy),
    .o_overflow      (o_overflow),
    .o_dbg_state     (o_dbg_state),
    .o_dbg_rr_ptr    (o_dbg_rr_ptr)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int r = 0; r < NR; r++) begin
      i_valid[r]          = v_r[r];
      i_last[r]           = l_r[r];
      i_data[r*DW +: DW]  = d_r[r];
    end
  end

  // Word tag: owner, scenario, packet number, beat number
  function automatic logic [DW-1:0] mk(input int r, input int pkt, input int b);
    return {8'(r), 8'(scen), 8'(pkt), 8'(b)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every FIFO write must match the head of the expected queue
  always @(negedge clk) begin
    #3;
    if (o_fifo_write_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%0h expected=none", o_fifo_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (o_fifo_data !== mon_exp || o_grant_id !== mon_exp[25:24] ||
            o_ready !== (4'b0001 << mon_exp[25:24]) || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL write_word actual=%0h/g%0d/rdy%b expected=%0h/g%0d/rdy%b",
                   o_fifo_data, o_grant_id, o_ready, mon_exp, mon_exp[25:24],
                   4'b0001 << mon_exp[25:24]);
        end
      end
    end
  end

  // Driver: present n words from requester r, holding each until it sees ready.
  // Optional gap: valid low for gap_len cycles before beat gap_at.
  task automatic drive_pkt(input int r, input int pkt, input int n, input bit with_last,
                           input int gap_at, input int gap_len);
    int waits;
    for (int b = 0; b < n; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          v_r[r] = 1'b0;
          l_r[r] = 1'b0;
          #3;
          chk("gap_hold", {o_fifo_write_en, o_busy, o_grant_id}, {1'b0, 1'b1, 2'(r)});
        end
      end
      @(negedge clk);
      v_r[r] = 1'b1;
      l_r[r] = with_last && (b == n - 1);
      d_r[r] = mk(r, pkt, b);
      waits = 0;
      #2;
      while (o_ready[r] !== 1'b1) begin
        waits++;
        if (waits > 300) begin
          errors++;
          $display("FAIL ready_timeout actual=no_ready expected=ready req=%0d beat=%0d", r, b);
          return;
        end
        @(negedge clk);
        #2;
      end
    end
  endtask

  task automatic drop(input int r);
    @(negedge clk);
    v_r[r] = 1'b0;
    l_r[r] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d_left expected=0_left", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fifo_full = 1'b0;
    for (int r = 0; r < NR; r++) begin
      v_r[r] = 1'b0;
      l_r[r] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("reset_busy",  o_busy, 1'b0);
    chk("reset_ready", o_ready, 4'b0000);
    chk("reset_we",    o_fifo_write_en, 1'b0);
    chk("reset_grant", o_grant_id, 2'd0);
    chk("reset_rr",    o_dbg_rr_ptr, 2'd0);
    chk("reset_ovf",   o_overflow, 1'b0);
    chk("reset_state", o_dbg_state, 1'b0);
  endtask

  initial begin
    int s;
    int n;
    int exp_c[$];
    checks = 0;
    errors = 0;
    cyc = 0;
    scen = 0;
    rst = 1'b1;
    fifo_full = 1'b0;
    for (int r = 0; r < NR; r++) begin
      v_r[r] = 1'b0;
      l_r[r] = 1'b0;
      d_r[r] = '0;
    end

    // 1: requesters 0 and 2, 3-word packets
    do_reset();
    scen = 1;
    for (int b = 0; b < 3; b++) exp_q.push_back(mk(0, 0, b));
    for (int b = 0; b < 3; b++) exp_q.push_back(mk(2, 0, b));
    wr_cyc.delete();
    @(negedge clk);
    s = cyc;
    fork
      begin drive_pkt(0, 0, 3, 1'b1, -1, 0); drop(0); end
      begin drive_pkt(2, 0, 3, 1'b1, -1, 0); drop(2); end
    join
    drain();
    exp_c = '{2, 3, 4, 6, 7, 8};
    for (int i = 0; i < 6; i++)
      chk("s1_write_cycle", (i < wr_cyc.size()) ? 64'(wr_cyc[i] - s) : 64'hdead, 64'(exp_c[i]));
    chk("s1_rr_end", o_dbg_rr_ptr, 2'd3);

    // 2: all four valid, 1-word packets
    do_reset();
    scen = 2;
    exp_q.push_back(mk(0, 0, 0));
    exp_q.push_back(mk(1, 0, 0));
    exp_q.push_back(mk(2, 0, 0));
    exp_q.push_back(mk(3, 0, 0));
    exp_q.push_back(mk(0, 1, 0));
    wr_cyc.delete();
    @(negedge clk);
    s = cyc;
    fork
      begin drive_pkt(0, 0, 1, 1'b1, -1, 0); drive_pkt(0, 1, 1, 1'b1, -1, 0); drop(0); end
      begin drive_pkt(1, 0, 1, 1'b1, -1, 0); drop(1); end
      begin drive_pkt(2, 0, 1, 1'b1, -1, 0); drop(2); end
      begin drive_pkt(3, 0, 1, 1'b1, -1, 0); drop(3); end
    join
    drain();
    exp_c = '{2, 4, 6, 8, 10};
    for (int i = 0; i < 5; i++)
      chk("s2_write_cycle", (i < wr_cyc.size()) ? 64'(wr_cyc[i] - s) : 64'hdead, 64'(exp_c[i]));

    // 3: owner 1 stalled by a full FIFO for 5 cycles
    scen = 3;
    for (int b = 0; b < 4; b++) exp_q.push_back(mk(1, 0, b));
    wr_cyc.delete();
    fork
      begin drive_pkt(1, 0, 4, 1'b1, -1, 0); drop(1); end
      begin
        n = 0;
        while (wr_cyc.size() < 2 && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("s3_reach_word2", 64'(wr_cyc.size() >= 2), 64'd1);
        fifo_full = 1'b1;
        s = cyc;
        for (int i = 0; i < 5; i++) begin
          #3;
          chk("s3_full_hold", {o_ready, o_fifo_write_en, o_busy, o_grant_id},
              {4'b0000, 1'b0, 1'b1, 2'd1});
          @(negedge clk);
        end
        fifo_full = 1'b0;
        #3;
        chk("s3_resume_we", {o_fifo_write_en, o_grant_id}, {1'b1, 2'd1});
      end
    join
    drain();
    chk("s3_stall_gap", (wr_cyc.size() >= 3) ? 64'(wr_cyc[2] - wr_cyc[1]) : 64'hdead, 64'd6);

    // 4: requester 3, 17 words without last, then one closing word
    scen = 4;
    chk("s4_ovf_before", o_overflow, 1'b0);
    for (int b = 0; b < 18; b++) exp_q.push_back(mk(3, 0, b));
    wr_cyc.delete();
    drive_pkt(3, 0, 18, 1'b1, -1, 0);
    drop(3);
    drain();
    chk("s4_first16_span", (wr_cyc.size() >= 17) ? 64'(wr_cyc[15] - wr_cyc[0]) : 64'hdead, 64'd15);
    chk("s4_rearb_gap", (wr_cyc.size() >= 17) ? 64'(wr_cyc[16] - wr_cyc[15]) : 64'hdead, 64'd2);
    chk("s4_ovf_set", o_overflow, 1'b1);

    // 5: reset in the middle of requester 1's 4-word packet
    scen = 5;
    exp_q.push_back(mk(2, 0, 0));
    drive_pkt(2, 0, 1, 1'b1, -1, 0);
    drop(2);
    drain();
    chk("s5_rr_pre", o_dbg_rr_ptr, 2'd3);
    for (int b = 0; b < 4; b++) exp_q.push_back(mk(1, 0, b));
    exp_q.push_back(mk(3, 0, 0));
    wr_cyc.delete();
    fork
      begin drive_pkt(1, 0, 4, 1'b1, -1, 0); drop(1); end
      begin wait (rst === 1'b1); drive_pkt(3, 0, 1, 1'b1, -1, 0); drop(3); end
      begin
        n = 0;
        while (wr_cyc.size() < 2 && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("s5_reach_word2", 64'(wr_cyc.size() >= 2), 64'd1);
        chk("s5_ovf_sticky", o_overflow, 1'b1);
        rst = 1'b1;
        #3;
        chk("s5_during_rst", {o_ready, o_fifo_write_en}, {4'b0000, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("s5_after_rst", {o_busy, o_ready, o_fifo_write_en, o_dbg_rr_ptr, o_grant_id, o_overflow},
            {1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0});
      end
    join
    drain();

    // 6: owner 0 pauses mid-packet while requester 1 waits
    scen = 6;
    for (int b = 0; b < 4; b++) exp_q.push_back(mk(0, 0, b));
    exp_q.push_back(mk(1, 0, 0));
    wr_cyc.delete();
    fork
      begin drive_pkt(0, 0, 4, 1'b1, 2, 3); drop(0); end
      begin drive_pkt(1, 0, 1, 1'b1, -1, 0); drop(1); end
    join
    drain();
    chk("s6_gap_span", (wr_cyc.size() >= 3) ? 64'(wr_cyc[2] - wr_cyc[1]) : 64'hdead, 64'd4);
    chk("s6_idle_end", {o_busy, o_fifo_write_en}, {1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL expose parameters, one per line:
- NUM_REQ, default 4, number of requesters (2..8)
- DATA_WIDTH, default 32, word width
- MAX_BEATS, default 16, maximum words per packet
REQ-002 The block SHALL expose ports, one per line:
- i_clk  input  1  sole clock, rising edge
- i_rst  input  1  synchronous, active-high reset
- i_valid  input  NUM_REQ  per-requester word valid
- i_last  input  NUM_REQ  per-requester final word of packet
- i_data  input  NUM_REQ*DATA_WIDTH  requester r word at bits [r*DATA_WIDTH +: DATA_WIDTH]
- o_ready  output  NUM_REQ  per-requester accept
- o_fifo_write_en  output  1  write strobe to downstream FIFO
- o_fifo_data  output  DATA_WIDTH  word to downstream FIFO
- i_fifo_full  input  1  downstream FIFO full
- o_grant_id  output  clog2(NUM_REQ)  current owner index
- o_busy  output  1  packet in progress (LOCKED)
- o_overflow  output  1  sticky: packet exceeded MAX_BEATS
REQ-003 The block SHALL have one clock domain, i_clk; i_rst SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE and LOCKED.
REQ-005 In IDLE with any i_valid high, the next-cycle owner SHALL be the first valid requester at or after rr_ptr, scanning upward with wrap.
- On that edge: state -> LOCKED, o_grant_id <= owner, beat counter <= 0.
- Arbitration latency SHALL be one cycle, with no transfer in the IDLE cycle.
REQ-006 In IDLE, o_ready SHALL be all zero and o_fifo_write_en SHALL be 0.
REQ-007 In LOCKED:
- o_ready[o_grant_id] = !i_fifo_full; every other o_ready bit = 0.
- A transfer occurs when i_valid[g] && o_ready[g], where g = o_grant_id.
REQ-008 o_fifo_write_en SHALL equal the transfer condition combinationally, and o_fifo_data SHALL equal the owner's i_data slice combinationally (zero-latency passthrough).
REQ-009 A transfer with i_last[g] high SHALL, on that edge:
- return the FSM to IDLE
- set rr_ptr <= (g+1) mod NUM_REQ
REQ-010 Each transfer SHALL increment the beat counter (width clog2(MAX_BEATS+1)).
- A transfer without i_last while the counter = MAX_BEATS-1 SHALL force release (IDLE, rr_ptr advanced, as REQ-009).
- The same transfer SHALL set o_overflow, which stays 1 until reset.
REQ-011 While i_fifo_full is high in LOCKED, no transfer SHALL occur, state and counter SHALL hold, and ownership SHALL NOT change.
REQ-012 Deasserting i_valid[g] mid-packet SHALL NOT release ownership; the block SHALL wait indefinitely for i_last.
REQ-013 A requester's i_valid going high while another requester owns the grant SHALL NOT affect the current packet; it is considered at the next IDLE.
REQ-014 o_busy SHALL be 1 exactly when the state is LOCKED.
REQ-015 A single-word packet (i_valid and i_last together on the first LOCKED beat) SHALL complete in one LOCKED cycle.
REQ-016 Back-to-back packets SHALL incur exactly one IDLE cycle between the last word of one packet and the first word of the next.

Reset
REQ-017 With i_rst high at a clock edge, the following SHALL take effect and override all in-flight activity, including mid-packet:
- state = IDLE
- rr_ptr = 0, o_grant_id = 0
- beat counter = 0, o_overflow = 0
REQ-018 During and after reset, o_ready = 0, o_fifo_write_en = 0 and o_busy = 0 until a new grant occurs; o_fifo_data is don't-care when write_en = 0.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- After reset, requesters 0 and 2 valid, 3-word packets -> owner 0 first (o_grant_id=0 from cycle 2), 3 writes, 1 idle cycle, then owner 2, 3 writes; rr_ptr=3 at end.
- All 4 requesters continuously valid, 1-word packets -> grant order 0,1,2,3,0; one write every 2 cycles.
- Owner 1 mid-packet, i_fifo_full=1 for 5 cycles -> o_ready=0, o_fifo_write_en=0, o_grant_id stays 1; writes resume the cycle full drops.
- Requester 3 sends 17 words without i_last (MAX_BEATS=16) -> release after word 16, o_overflow=1 and sticky, word 17 starts a new arbitration.
- i_rst asserted after word 2 of a 4-word packet from requester 1 -> next cycle o_busy=0, o_ready=0, rr_ptr=0; requester 1 then regains the grant first.
- Requester 0 drops i_valid for 3 cycles mid-packet while requester 1 is valid -> grant stays 0, no write from requester 1 until requester 0's i_last.
